// File: rtl/mem_bus_unit.sv
// Memory sequencer: turns control-FSM strobes into a valid/ack bus transaction,
// owns IR and MDR, and traps misaligned, erroring or timed-out accesses.
module mem_bus_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        IorD,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        mem_stall,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic        mem_fault,
  output logic [31:0] fault_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, FAULT} state_e;

  state_e      state_q;
  logic        bus_req_q, bus_we_q, mem_fault_q;
  logic [31:0] bus_addr_q, bus_wdata_q, instr_q, mdr_q, fault_addr_q;
  logic [3:0]  bus_be_q;
  logic [1:0]  lo_q;
  logic [2:0]  f3_q;
  logic [7:0]  wait_q;

  logic        start, size_ok, misaligned;
  logic [31:0] addr, wdata_d, ext_d;
  logic [2:0]  f3_d;
  logic [3:0]  be_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    addr       = IorD ? alu_out : pc;
    start      = (state_q == IDLE) && (MemRead || MemWrite);
    f3_d       = IorD ? instr_q[14:12] : 3'b010;
    size_ok    = 1'b1;
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = store_data;
    case (f3_d)
      3'b000, 3'b100: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      3'b001, 3'b101: begin
        be_d       = 4'b0011 << addr[1:0];
        wdata_d    = {2{store_data[15:0]}};
        misaligned = addr[0];
      end
      3'b010:  misaligned = |addr[1:0];
      default: size_ok = 1'b0;
    endcase
  end

  // Load lane select uses the low address bits latched at request time.
  always_comb begin
    byte_sel = bus_rdata[{lo_q, 3'b000} +: 8];
    half_sel = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ext_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_d = {24'b0, byte_sel};
      3'b001:  ext_d = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_d = {16'b0, half_sel};
      default: ext_d = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      instr_q      <= 32'h0000_0013;
      mdr_q        <= '0;
      mem_fault_q  <= 1'b0;
      fault_addr_q <= '0;
      lo_q         <= '0;
      f3_q         <= '0;
      wait_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!size_ok || misaligned) begin
              state_q      <= FAULT;
              mem_fault_q  <= 1'b1;
              fault_addr_q <= addr;
            end else begin
              state_q     <= ACCESS;
              bus_req_q   <= 1'b1;
              bus_we_q    <= MemWrite;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
              lo_q        <= addr[1:0];
              f3_q        <= f3_d;
              wait_q      <= '0;
            end
          end
        end
        ACCESS: begin
          if (bus_err || (!bus_ack && wait_q == 8'(TIMEOUT - 1))) begin
            state_q      <= FAULT;
            bus_req_q    <= 1'b0;
            mem_fault_q  <= 1'b1;
            fault_addr_q <= {bus_addr_q[31:2], lo_q};
          end else if (bus_ack) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              if (IRWrite && !IorD) instr_q <= bus_rdata;
              else                  mdr_q   <= ext_d;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_stall  = start || (state_q == ACCESS && !bus_ack && !bus_err) || (state_q == FAULT);
  assign instr      = instr_q;
  assign mdr        = mdr_q;
  assign mem_fault  = mem_fault_q;
  assign fault_addr = fault_addr_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: fetch/load/store paths, extension, faults,
// timeout and mid-access reset, each against hand-computed values.
module tb_mem_bus_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, IRWrite, IorD;
  logic [31:0] pc, alu_out, store_data;
  logic        mem_stall, mem_fault, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] instr, mdr, fault_addr, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int          checks = 0;
  int          errors = 0;
  int          nstall;
  int          nreq;
  logic        o_req, o_we;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;

  mem_bus_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD),
    .pc(pc), .alu_out(alu_out), .store_data(store_data),
    .mem_stall(mem_stall), .instr(instr), .mdr(mdr),
    .mem_fault(mem_fault), .fault_addr(fault_addr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; IRWrite = 0; IorD = 0;
    bus_ack = 0; bus_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  // Strobes held from the start cycle until the response edge; response on access cycle 'waits'.
  task automatic do_access(input logic mr, input logic mw, input logic irw, input logic iord,
                           input logic [31:0] a_pc, input logic [31:0] a_alu, input logic [31:0] a_sd,
                           input int waits, input logic [31:0] rd, input logic with_err);
    @(negedge clk);
    MemRead = mr; MemWrite = mw; IRWrite = irw; IorD = iord;
    pc = a_pc; alu_out = a_alu; store_data = a_sd;
    bus_ack = 0; bus_err = 0;
    nstall = 0;
    #1 if (mem_stall) nstall++;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      bus_ack   = (i == waits);
      bus_err   = with_err && (i == waits);
      bus_rdata = rd;
      #1;
      if (i == 0) begin
        o_req = bus_req; o_we = bus_we; o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata;
      end
      if (mem_stall) nstall++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic fetch(input logic [31:0] a_pc, input logic [31:0] rd);
    do_access(1, 0, 1, 0, a_pc, 32'h0, 32'h0, 0, rd, 0);
  endtask

  initial begin
    rst = 0; idle_inputs();
    pc = 0; alu_out = 0; store_data = 0; bus_rdata = 0;
    #12;
    chk("rst_req", {31'b0, bus_req}, 0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_mdr", mdr, 0);
    chk("rst_fault", {31'b0, mem_fault}, 0);
    chk("rst_faddr", fault_addr, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", {28'b0, bus_be}, 0);
    chk("rst_stall", {31'b0, mem_stall}, 0);
    rst = 1;

    // Zero-wait fetch
    fetch(32'h100, 32'h00A0_0093);
    chk("f_req", {31'b0, o_req}, 1);
    chk("f_addr", o_addr, 32'h100);
    chk("f_be", {28'b0, o_be}, 4'hF);
    chk("f_we", {31'b0, o_we}, 0);
    chk("f_instr", instr, 32'h00A0_0093);
    chk("f_stall", nstall, 1);
    chk("f_req_drop", {31'b0, bus_req}, 0);

    // Ack outside ACCESS must not capture
    @(negedge clk);
    IRWrite = 1; bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    chk("idle_ack", instr, 32'h00A0_0093);

    // LB (funct3 000 in current IR), three wait cycles
    do_access(1, 0, 0, 1, 32'h0, 32'h203, 32'h0, 3, 32'h8011_2233, 0);
    chk("lb_addr", o_addr, 32'h200);
    chk("lb_be", {28'b0, o_be}, 4'h8);
    chk("lb_mdr", mdr, 32'hFFFF_FF80);
    chk("lb_stall", nstall, 4);

    fetch(32'h104, 32'h0000_4003);
    do_access(1, 0, 0, 1, 32'h0, 32'h203, 32'h0, 3, 32'h8011_2233, 0);
    chk("lbu_mdr", mdr, 32'h0000_0080);

    fetch(32'h108, 32'h0000_1023);
    do_access(0, 1, 0, 1, 32'h0, 32'h102, 32'h1234_ABCD, 0, 32'h5555_5555, 0);
    chk("sh_we", {31'b0, o_we}, 1);
    chk("sh_addr", o_addr, 32'h100);
    chk("sh_be", {28'b0, o_be}, 4'hC);
    chk("sh_wdata", o_wdata, 32'hABCD_ABCD);
    chk("sh_mdr", mdr, 32'h0000_0080);

    do_access(1, 0, 0, 1, 32'h0, 32'h202, 32'h0, 1, 32'h8011_2233, 0);
    chk("lh_be", {28'b0, o_be}, 4'hC);
    chk("lh_mdr", mdr, 32'hFFFF_8011);

    // Misaligned LW
    fetch(32'h10C, 32'h0000_2003);
    @(negedge clk);
    MemRead = 1; IorD = 1; alu_out = 32'h101;
    #1 chk("mis_stall0", {31'b0, mem_stall}, 1);
    nreq = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 if (bus_req) nreq++;
    end
    chk("mis_req", nreq, 0);
    chk("mis_fault", {31'b0, mem_fault}, 1);
    chk("mis_faddr", fault_addr, 32'h101);
    idle_inputs();
    #1 chk("mis_stall", {31'b0, mem_stall}, 1);

    // Timeout with TIMEOUT=4
    do_reset();
    @(negedge clk);
    MemRead = 1; IRWrite = 1; pc = 32'h300;
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 if (bus_req) nreq++;
    end
    chk("to_req_cycles", nreq, 4);
    chk("to_fault", {31'b0, mem_fault}, 1);
    chk("to_faddr", fault_addr, 32'h300);
    chk("to_stall", {31'b0, mem_stall}, 1);

    // Ack and err together on an LB (reset IR has funct3 000)
    do_reset();
    do_access(1, 0, 0, 1, 32'h0, 32'h401, 32'h0, 0, 32'hDEAD_BEEF, 1);
    chk("err_fault", {31'b0, mem_fault}, 1);
    chk("err_faddr", fault_addr, 32'h401);
    chk("err_mdr", mdr, 0);
    chk("err_instr", instr, 32'h0000_0013);
    chk("err_req", {31'b0, bus_req}, 0);

    // Reset during the second ACCESS cycle, then a clean fetch
    do_reset();
    fetch(32'h500, 32'h1111_1111);
    @(negedge clk);
    MemRead = 1; IRWrite = 1; pc = 32'h504;
    @(negedge clk);
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h2222_2222;
    rst = 0;
    #1;
    chk("arst_req", {31'b0, bus_req}, 0);
    chk("arst_instr", instr, 32'h0000_0013);
    @(negedge clk);
    idle_inputs();
    rst = 1;
    fetch(32'h508, 32'h1234_5678);
    chk("post_addr", o_addr, 32'h508);
    chk("post_instr", instr, 32'h1234_5678);
    chk("post_stall", nstall, 1);

    // Unsupported funct3 on a data access
    fetch(32'h50C, 32'h0000_3003);
    @(negedge clk);
    MemRead = 1; IorD = 1; alu_out = 32'h600;
    @(negedge clk);
    #1;
    chk("f3_fault", {31'b0, mem_fault}, 1);
    chk("f3_faddr", fault_addr, 32'h600);
    chk("f3_req", {31'b0, bus_req}, 0);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
